// File: rtl/scroll_ctrl.sv
// Control stage for the 7-segment text scroller: debounced buttons drive a run/pause
// FSM with four speeds and a direction toggle; emits a one-cycle step and a dir level.
module scroll_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SPEED0_CYCLES   = 25000000,
  parameter int SPEED1_CYCLES   = 20000000,
  parameter int SPEED2_CYCLES   = 9000000,
  parameter int SPEED3_CYCLES   = 4000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [2:0] key_n,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int TICK_W = 25;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_PAUSED = 1'b1;

  function automatic logic [TICK_W-1:0] period_of(input logic [1:0] s);
    case (s)
      2'd0:    period_of = TICK_W'(SPEED0_CYCLES);
      2'd1:    period_of = TICK_W'(SPEED1_CYCLES);
      2'd2:    period_of = TICK_W'(SPEED2_CYCLES);
      default: period_of = TICK_W'(SPEED3_CYCLES);
    endcase
  endfunction

  function automatic logic [1:0] next_speed(input logic [1:0] s);
    next_speed = s + 2'd1;
  endfunction

  logic [2:0]        r_key_p0;
  logic [2:0]        r_key_p1;
  logic [2:0]        r_stable;
  logic [2:0]        r_stable_d;
  logic [DB_W-1:0]   r_db_cnt [3];
  logic [TICK_W-1:0] r_tick_cnt;
  logic [0:0]        r_state;
  logic              r_step;
  logic              r_dir;
  logic [1:0]        r_speed;

  logic [2:0]        w_evt;
  logic              w_run;
  logic [TICK_W-1:0] w_period;
  logic              w_tc;
  logic              w_spd_evt;
  logic              w_single;

  // Stage p0/p1: two-flop synchronizer, released (1) out of reset
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_key_p0 <= 3'b111;
      r_key_p1 <= 3'b111;
    end else begin
      r_key_p0 <= key_n;
      r_key_p1 <= r_key_p0;
    end
  end

  // Debounce: any sample equal to the stable value restarts the count
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
      r_stable   <= 3'b111;
      r_stable_d <= 3'b111;
    end else begin
      r_stable_d <= r_stable;
      for (int k = 0; k < 3; k++) begin
        if (r_key_p1[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_stable[k] <= r_key_p1[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Press event: one cycle after the stable level falls; releases are ignored
  assign w_evt     = r_stable_d & ~r_stable;
  assign w_run     = (r_state == ST_RUN);
  assign w_period  = period_of(r_speed);
  assign w_tc      = w_run && (r_tick_cnt == (w_period - TICK_W'(1)));
  assign w_spd_evt = w_run & w_evt[1];
  assign w_single  = ~w_run & w_evt[1];

  // Control stage: every event sees the pre-update state of this cycle
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_RUN;
      r_step     <= 1'b0;
      r_dir      <= 1'b1;
      r_speed    <= 2'd1;
      r_tick_cnt <= '0;
    end else begin
      r_step <= w_tc | w_single;
      if (w_evt[0]) r_state <= (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
      if (w_evt[2]) r_dir   <= ~r_dir;
      if (w_spd_evt) r_speed <= next_speed(r_speed);
      if (!w_run || w_evt[0] || w_spd_evt || w_tc) r_tick_cnt <= '0;
      else r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  assign step   = r_step;
  assign dir    = r_dir;
  assign speed  = r_speed;
  assign paused = (r_state == ST_PAUSED);

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl: expected step pulses (cycle stamp plus output
// snapshot) are queued ahead of time and a monitor pops one per observed step.
module tb_scroll_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [2:0] key_n    = 3'b111;
  logic       step;
  logic       dir;
  logic [1:0] speed;
  logic       paused;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] spd;
    logic       dir;
    logic       pau;
  } exp_t;

  exp_t q[$];
  exp_t e;

  scroll_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SPEED0_CYCLES  (16),
    .SPEED1_CYCLES  (12),
    .SPEED2_CYCLES  (8),
    .SPEED3_CYCLES  (4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .key_n   (key_n),
    .step    (step),
    .dir     (dir),
    .speed   (speed),
    .paused  (paused)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= RESET ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, expv, cyc);
  endtask

  task automatic push(input int c, input logic [1:0] s, input logic d, input logic p);
    exp_t x;
    x.cyc = c; x.spd = s; x.dir = d; x.pau = p;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLOCK_50);
  endtask

  task automatic press(input int c, input logic [2:0] mask, input int hold);
    wait_cyc(c);
    key_n = key_n & ~mask;
    repeat (hold) @(negedge CLOCK_50);
    key_n = key_n | mask;
  endtask

  // Monitor: every observed step must match the head of the scoreboard
  always @(negedge CLOCK_50) begin
    if (!RESET && step) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_step: step at cyc %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc == cyc && e.spd == speed && e.dir == dir && e.pau == paused) n_pass++;
        else $display("FAIL step_event: got cyc %0d spd %0d dir %0d pau %0d, expected cyc %0d spd %0d dir %0d pau %0d",
                      cyc, speed, dir, paused, e.cyc, e.spd, e.dir, e.pau);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLOCK_50);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 1);
    chk("rst_speed", speed, 1);
    chk("rst_paused", paused, 0);

    for (int c = 12; c <= 60; c += 12) push(c, 2'd1, 1'b1, 1'b0);
    for (int c = 74; c <= 106; c += 8) push(c, 2'd2, 1'b1, 1'b0);
    push(127, 2'd2, 1'b1, 1'b1);
    push(147, 2'd2, 1'b1, 1'b1);
    push(185, 2'd2, 1'b1, 1'b0);
    push(193, 2'd2, 1'b1, 1'b0);
    for (int c = 201; c <= 213; c += 4) push(c, 2'd3, 1'b1, 1'b0);
    push(217, 2'd0, 1'b1, 1'b0);
    push(233, 2'd0, 1'b1, 1'b0);
    push(249, 2'd0, 1'b0, 1'b0);
    push(265, 2'd0, 1'b0, 1'b0);
    for (int c = 307; c <= 343; c += 12) push(c, 2'd1, 1'b0, 1'b0);

    RESET = 1'b0;

    // KEY1 glitches, then a real held press at cycle 59
    wait_cyc(50); key_n[1] = 1'b0;
    wait_cyc(52); key_n[1] = 1'b1;
    wait_cyc(53); key_n[1] = 1'b0;
    wait_cyc(55); key_n[1] = 1'b1;
    wait_cyc(58);
    chk("glitch_speed", speed, 1);
    press(59, 3'b010, 10);
    wait_cyc(70);
    chk("speed_up", speed, 2);

    press(100, 3'b001, 6);
    wait_cyc(110);
    chk("paused_on", paused, 1);
    press(120, 3'b010, 6);
    press(140, 3'b010, 6);
    wait_cyc(160);
    chk("paused_hold", paused, 1);
    chk("paused_speed", speed, 2);

    press(170, 3'b001, 6);
    press(190, 3'b010, 6);
    press(210, 3'b010, 6);
    wait_cyc(220);
    chk("speed_wrap", speed, 0);
    press(240, 3'b100, 6);
    wait_cyc(250);
    chk("dir_toggle", dir, 0);

    press(270, 3'b011, 6);
    wait_cyc(280);
    chk("combo_pause", paused, 1);
    chk("combo_speed", speed, 1);
    press(300, 3'b011, 6);
    wait_cyc(310);
    chk("combo_resume", paused, 0);

    // Reset while step is high and a KEY2 debounce is mid-count
    wait_cyc(339); key_n[2] = 1'b0;
    wait_cyc(343);
    #2;
    RESET = 1'b1;
    key_n = 3'b111;
    #1;
    chk("arst_step", step, 0);
    chk("arst_dir", dir, 1);
    chk("arst_speed", speed, 1);
    chk("arst_paused", paused, 0);
    chk("run1_drained", q.size(), 0);
    for (int c = 12; c <= 36; c += 12) push(c, 2'd1, 1'b1, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;

    wait_cyc(40);
    chk("run2_drained", q.size(), 0);
    chk("end_dir", dir, 1);
    chk("end_paused", paused, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
